// File: rtl/async_sram_pkg.sv
// Shared types for the async SRAM controller: FSM state encoding and counter sizing helper.
package async_sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((r < 32) && ((32'd1 << r) < v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/async_sram_dq_buf.sv
// SRAM data-bus pad: tri-state write driver plus a capture register for read data.
module async_sram_dq_buf #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_oe,
  input  logic              i_cap,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_mask,
  output logic [DATA_W-1:0] o_rdata,
  inout  wire  [DATA_W-1:0] io_dq
);

  logic [DATA_W-1:0] r_rdata;

  assign io_dq   = i_oe ? i_wdata : 'z;
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_cap) begin
      r_rdata <= io_dq & i_mask;
    end
  end

endmodule

// File: rtl/async_sram_ctrl.sv
// Valid/ready to asynchronous SRAM strobe controller with wait states and read->write turnaround.
// Define ASYNC_SRAM_CTRL_PIPE_EN to accept the next request during the final cycle of an access.
module async_sram_ctrl
  import async_sram_pkg::*;
#(
  parameter  int ADDR_W  = 18,
  parameter  int DATA_W  = 16,
  parameter  int RD_WAIT = 2,
  parameter  int WR_WAIT = 2,
  parameter  int TURN    = 1,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [BE_W-1:0]   REQ_BE,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [BE_W-1:0]   SRAM_BE_N,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

`ifdef ASYNC_SRAM_CTRL_PIPE_EN
  localparam bit L_PIPE = 1'b1;
`else
  localparam bit L_PIPE = 1'b0;
`endif

  localparam int          MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int          MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
  localparam int unsigned CNT_W    = clog2(unsigned'(MAX_WAIT) + 1);
  localparam logic [CNT_W-1:0] L_RD_LD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] L_WR_LD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] L_TURN_LD = (TURN > 0) ? CNT_W'(TURN - 1) : '0;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready, r_pend;
  logic              r_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_rd_valid;
  logic [BE_W-1:0]   r_be_n;
  logic [ADDR_W-1:0] r_addr;

  logic              w_acc, w_cap, w_go_setup, w_src_we;
  logic [ADDR_W-1:0] w_src_addr;
  logic [BE_W-1:0]   w_src_be;
  logic [DATA_W-1:0] w_mask, w_rdata;

  always_comb begin
    w_acc      = REQ_VALID & r_ready;
    w_src_we   = w_acc ? REQ_WE   : r_we;
    w_src_addr = w_acc ? REQ_ADDR : r_req_addr;
    w_src_be   = w_acc ? REQ_BE   : r_be;
    w_cap      = (r_state == S_ACCESS) && !r_we && (r_cnt == '0);
    w_mask     = '0;
    for (int unsigned i = 0; i < BE_W; i++) w_mask[i*8 +: 8] = {8{r_be[i]}};
    // A write accepted at the end of a read must still pass through TURN (via r_pend).
    unique case (r_state)
      S_IDLE:   w_go_setup = w_acc;
      S_ACCESS: w_go_setup = w_cap && w_acc && !(REQ_WE && (TURN > 0));
      S_HOLD:   w_go_setup = w_acc;
      S_TURN:   w_go_setup = (r_cnt == '0) && r_pend;
      default:  w_go_setup = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_pend     <= 1'b0;
      r_we       <= 1'b0;
      r_req_addr <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_be_n     <= '1;
      r_addr     <= '0;
      r_dq_oe    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_cap;
      if (w_acc) begin
        r_we       <= REQ_WE;
        r_req_addr <= REQ_ADDR;
        r_wdata    <= REQ_WDATA;
        r_be       <= REQ_BE;
      end
      if (w_go_setup) begin
        r_state <= S_SETUP;
        r_ready <= 1'b0;
        r_pend  <= 1'b0;
        r_ce_n  <= 1'b0;
        r_oe_n  <= w_src_we;
        r_we_n  <= 1'b1;
        r_be_n  <= ~w_src_be;
        r_addr  <= w_src_addr;
        r_dq_oe <= w_src_we;
      end else begin
        unique case (r_state)
          S_IDLE: r_ready <= 1'b1;
          S_SETUP: begin
            r_state <= S_ACCESS;
            r_cnt   <= r_we ? L_WR_LD : L_RD_LD;
            r_we_n  <= ~r_we;
            r_ready <= L_PIPE && !r_we && (RD_WAIT == 1);
          end
          S_ACCESS: begin
            if (r_cnt != '0) begin
              r_cnt   <= r_cnt - 1'b1;
              r_ready <= L_PIPE && !r_we && (r_cnt == CNT_W'(1));
            end else if (r_we) begin
              r_state <= S_HOLD;
              r_we_n  <= 1'b1;
              r_ready <= L_PIPE;
            end else begin
              r_oe_n  <= 1'b1;
              r_ce_n  <= 1'b1;
              r_be_n  <= '1;
              if (TURN > 0) begin
                r_state <= S_TURN;
                r_cnt   <= L_TURN_LD;
                r_pend  <= w_acc;
                r_ready <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            r_state <= S_IDLE;
            r_ce_n  <= 1'b1;
            r_be_n  <= '1;
            r_dq_oe <= 1'b0;
            r_ready <= 1'b1;
          end
          S_TURN: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  async_sram_dq_buf #(.DATA_W(DATA_W)) u_dq_buf (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_oe    (r_dq_oe),
    .i_cap   (w_cap),
    .i_wdata (r_wdata),
    .i_mask  (w_mask),
    .o_rdata (w_rdata),
    .io_dq   (SRAM_DQ)
  );

  assign REQ_READY = r_ready;
  assign RD_VALID  = r_rd_valid;
  assign RD_DATA   = w_rdata;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_BE_N = r_be_n;
  assign SRAM_ADDR = r_addr;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed bench for async_sram_ctrl with a behavioural SRAM on the pins (RD_WAIT=2, WR_WAIT=2, TURN=1).
module tb_async_sram_ctrl;

`ifdef ASYNC_SRAM_CTRL_PIPE_EN
  localparam int RD_GAP = 3;
  localparam int WR_GAP = 4;
`else
  localparam int RD_GAP = 5;
  localparam int WR_GAP = 5;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID, REQ_WE;
  logic        REQ_READY, RD_VALID;
  logic [17:0] REQ_ADDR;
  logic [15:0] REQ_WDATA, RD_DATA;
  logic [1:0]  REQ_BE, SRAM_BE_N;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;

  logic        probe_en = 1'b0;
  logic        mon_en   = 1'b0;
  logic [15:0] mem [0:262143];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  async_sram_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2), .TURN(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE), .RD_VALID(RD_VALID),
    .RD_DATA(RD_DATA), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_BE_N(SRAM_BE_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM drives the whole word on reads; the probe pulls the bus to 0 when checking for release.
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 'z;
  assign SRAM_DQ = probe_en ? 16'h0000 : 'z;

  always @(posedge SRAM_WE_N) begin
    if (!SRAM_CE_N) begin
      for (int i = 0; i < 2; i++)
        if (!SRAM_BE_N[i]) mem[SRAM_ADDR][i*8 +: 8] <= SRAM_DQ[i*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge CLK) begin
    if (mon_en && RST_N === 1'b1) check("oe_we_exclusive", SRAM_OE_N | SRAM_WE_N, 1'b1);
  end

  task automatic send(input logic we, input logic [17:0] a, input logic [15:0] d,
                      input logic [1:0] be);
    bit got;
    got = 1'b0;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = d; REQ_BE = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin got = 1'b1; break; end
    end
    if (!got) check("accept_timeout", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a, input logic [1:0] be,
                         output logic [15:0] data, output int lat);
    send(1'b0, a, 16'hC3C3, be);
    lat = -1; data = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (RD_VALID) begin lat = k; data = RD_DATA; break; end
    end
    if (lat < 0) check("rd_timeout", RD_VALID, 1'b1);
  endtask

  logic [15:0] rd, exp_d, mask;
  logic [15:0] shadow [0:7];
  logic [1:0]  rbe;
  int          lat, nacc, nrv, wacc, seen_rv, saw;
  int          rv_cyc [0:3];
  int          acc_cyc [0:1];

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_BE = '0;
    repeat (3) @(negedge CLK);
    check("rst_ce_n", SRAM_CE_N, 1'b1);
    check("rst_oe_n", SRAM_OE_N, 1'b1);
    check("rst_we_n", SRAM_WE_N, 1'b1);
    check("rst_be_n", SRAM_BE_N, 2'b11);
    check("rst_addr", SRAM_ADDR, 18'h0);
    check("rst_rd_valid", RD_VALID, 1'b0);
    check("rst_rd_data", RD_DATA, 16'h0);
    check("rst_ready", REQ_READY, 1'b0);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("ready_after_rst", REQ_READY, 1'b1);
    mon_en = 1'b1;

    send(1'b1, 18'h00010, 16'hA55A, 2'b11);
    do_read(18'h00010, 2'b11, rd, lat);
    check("rd1_latency", lat, 3);
    check("rd1_data", rd, 16'hA55A);

    send(1'b1, 18'h3FFFF, 16'hFFFF, 2'b11);
    send(1'b1, 18'h3FFFF, 16'h1234, 2'b01);
    do_read(18'h3FFFF, 2'b11, rd, lat);
    check("rd_top_lane0", rd, 16'hFF34);

    send(1'b1, 18'h00010, 16'hBEEF, 2'b00);
    do_read(18'h00010, 2'b11, rd, lat);
    check("be00_write_nochange", rd, 16'hA55A);
    do_read(18'h00010, 2'b00, rd, lat);
    check("be00_read_lat", lat, 3);
    check("be00_read_zero", rd, 16'h0000);
    do_read(18'h00010, 2'b10, rd, lat);
    check("be10_read", rd, 16'hA500);

    send(1'b1, 18'h00020, 16'h5AA5, 2'b11);
    @(negedge CLK);
    check("wsetup_ce_n", SRAM_CE_N, 1'b0);
    check("wsetup_we_n", SRAM_WE_N, 1'b1);
    check("wsetup_oe_n", SRAM_OE_N, 1'b1);
    check("wsetup_dq", SRAM_DQ, 16'h5AA5);
    check("wsetup_addr", SRAM_ADDR, 18'h00020);
    check("wsetup_be_n", SRAM_BE_N, 2'b00);
    @(negedge CLK);
    check("wacc1_we_n", SRAM_WE_N, 1'b0);
    @(negedge CLK);
    check("wacc2_we_n", SRAM_WE_N, 1'b0);
    @(negedge CLK);
    check("whold_we_n", SRAM_WE_N, 1'b1);
    check("whold_ce_n", SRAM_CE_N, 1'b0);
    check("whold_dq", SRAM_DQ, 16'h5AA5);
    @(negedge CLK);
    check("wend_ce_n", SRAM_CE_N, 1'b1);

    // read immediately followed by a write held valid
    send(1'b0, 18'h00020, 16'hC3C3, 2'b11);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 18'h00021; REQ_WDATA = 16'h0F0F; REQ_BE = 2'b11;
    seen_rv = 0; wacc = 0;
    for (int i = 0; i < 30 && !(seen_rv && wacc); i++) begin
      @(negedge CLK);
      if (RD_VALID) begin
        seen_rv = 1;
        check("turn_rd_data", RD_DATA, 16'h5AA5);
        probe_en = 1'b1; #1;
        check("turn_oe_n", SRAM_OE_N, 1'b1);
        check("turn_we_n", SRAM_WE_N, 1'b1);
        check("turn_dq_released", SRAM_DQ, 16'h0000);
        probe_en = 1'b0;
      end
      if (REQ_VALID && REQ_READY) begin
        @(posedge CLK); #1 REQ_VALID = 1'b0; wacc = 1;
      end
    end
    check("turn_seen", seen_rv + wacc, 2);
    do_read(18'h00021, 2'b11, rd, lat);
    check("rd_after_turn", rd, 16'h0F0F);

    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 18'h00010; REQ_BE = 2'b11;
    nacc = 0; nrv = 0;
    for (int i = 0; i < 60 && nrv < 4; i++) begin
      @(negedge CLK);
      if (RD_VALID) begin rv_cyc[nrv] = cyc; nrv++; end
      if (REQ_VALID && REQ_READY) begin
        nacc++;
        if (nacc == 4) begin @(posedge CLK); #1 REQ_VALID = 1'b0; end
      end
    end
    check("rd_burst_count", nrv, 4);
    check("rd_gap_01", rv_cyc[1] - rv_cyc[0], RD_GAP);
    check("rd_gap_23", rv_cyc[3] - rv_cyc[2], RD_GAP);
    check("rd_burst_data", RD_DATA, 16'hA55A);

    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 18'h00030; REQ_WDATA = 16'h1111; REQ_BE = 2'b11;
    nacc = 0;
    for (int i = 0; i < 40 && nacc < 2; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin
        acc_cyc[nacc] = cyc; nacc++;
        if (nacc == 2) begin @(posedge CLK); #1 REQ_VALID = 1'b0; end
      end
    end
    check("wr_burst_count", nacc, 2);
    check("wr_gap", acc_cyc[1] - acc_cyc[0], WR_GAP);

    for (int i = 0; i < 8; i++) begin
      shadow[i] = 16'($urandom);
      send(1'b1, 18'h00100 + 18'(i), shadow[i], 2'b11);
    end
    for (int i = 0; i < 8; i++) begin
      rbe = 2'($urandom_range(0, 3));
      mask = {{8{rbe[1]}}, {8{rbe[0]}}};
      exp_d = shadow[i] & mask;
      do_read(18'h00100 + 18'(i), rbe, rd, lat);
      check("rand_lat", lat, 3);
      check("rand_data", rd, exp_d);
    end

    // reset asserted in the middle of a write access
    send(1'b1, 18'h00040, 16'h9999, 2'b11);
    @(negedge CLK);
    @(negedge CLK);
    check("rstw_in_access", SRAM_WE_N, 1'b0);
    #2 RST_N = 1'b0;
    probe_en = 1'b1; #1;
    check("rstw_ce_n", SRAM_CE_N, 1'b1);
    check("rstw_we_n", SRAM_WE_N, 1'b1);
    check("rstw_oe_n", SRAM_OE_N, 1'b1);
    check("rstw_be_n", SRAM_BE_N, 2'b11);
    check("rstw_dq_released", SRAM_DQ, 16'h0000);
    check("rstw_ready", REQ_READY, 1'b0);
    probe_en = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (RD_VALID) saw = 1;
    end
    check("rstw_no_rd_valid", saw, 0);
    do_read(18'h00010, 2'b11, rd, lat);
    check("post_rst_read", rd, 16'hA55A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
